// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and the MDU result FIFO entry layout for the writeback port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } md_entry_t;

endpackage

// File: rtl/wb_md_fifo.sv
// MDU result FIFO: circular storage with per-entry live bits, kill-by-address,
// automatic popping of dead heads, and a pending-write lookup for decode.
module wb_md_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              push_dead,
    input  logic [REG_W-1:0]  push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_grant,
    input  logic              kill_en,
    input  logic [REG_W-1:0]  kill_addr,
    input  logic [REG_W-1:0]  qry_a,
    input  logic [REG_W-1:0]  qry_b,
    output logic              full,
    output logic              head_live,
    output logic [REG_W-1:0]  head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              hit_a,
    output logic              hit_b
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  live_q, live_d;
    logic [REG_W-1:0]  addr_q [DEPTH];
    logic [REG_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              head_present;
    logic              pop;

    // Head view and flow status seen by the grant logic.
    always_comb begin
        head_present = (count_q != '0);
        full         = (count_q == CNT_W'(DEPTH));
        head_live    = head_present && live_q[rd_ptr_q];
        head_addr    = addr_q[rd_ptr_q];
        head_data    = data_q[rd_ptr_q];
        // A granted head or a dead head leaves the queue; the grant only ever
        // targets a live head, so this is at most one pop per cycle.
        pop          = head_present && (pop_grant || !live_q[rd_ptr_q]);
    end

    // Next-state for storage, live bits, pointers and occupancy.
    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // A newer pipeline write supersedes every buffered result to that register.
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == kill_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        // Popped slots drop their live bit so the lookup only sees stored entries.
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end
        if (push) begin
            live_d[wr_ptr_q] = !push_dead;
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Decode lookup: does any live entry still owe a write to the queried register.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == qry_a)) hit_a = 1'b1;
            if (live_q[i] && (addr_q[i] == qry_b)) hit_b = 1'b1;
        end
        if (qry_a == '0) hit_a = 1'b0;
        if (qry_b == '0) hit_b = 1'b0;
    end

    // Control state: pointers, count and live bits clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; live bits gate its visibility.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter between the writeback stage and the MDU.
// Pipeline writes win unless the buffered MDU head has aged out, in which case
// the MDU result is forced through and writeback is stalled.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_we,
    input  logic [4:0]          wb_waddr,
    input  logic [31:0]         wb_wdata,
    input  logic                md_valid,
    input  logic [4:0]          md_waddr,
    input  logic [31:0]         md_wdata,
    output logic                md_ready,
    output logic                stall,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    input  logic [4:0]          qry_a,
    input  logic [4:0]          qry_b,
    output logic                hit_a,
    output logic                hit_b
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic              fifo_full;
    logic              head_live;
    logic [REG_W-1:0]  head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fifo_hit_a;
    logic              fifo_hit_b;
    logic              push;
    logic              push_dead;
    logic              force_wr;
    logic              wb_go;
    logic              md_go;
    logic [WAIT_W-1:0] wait_q, wait_d;

    wb_md_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_dead (push_dead),
        .push_addr (md_waddr),
        .push_data (md_wdata),
        .pop_grant (md_go),
        .kill_en   (wb_go),
        .kill_addr (wb_waddr),
        .qry_a     (qry_a),
        .qry_b     (qry_b),
        .full      (fifo_full),
        .head_live (head_live),
        .head_addr (head_addr),
        .head_data (head_data),
        .hit_a     (fifo_hit_a),
        .hit_b     (fifo_hit_b)
    );

    // Grant selection, write-port mux and the head age counter update.
    always_comb begin
        md_ready  = !rst && !fifo_full;
        // Results addressed to $0 are accepted and dropped.
        push      = md_valid && md_ready && (md_waddr != '0);
        // Aging depends on registered state only, so stall has no input path.
        force_wr  = head_live && (wait_q == WAIT_W'(MAX_WAIT));
        wb_go     = !rst && !force_wr && wb_we && (wb_waddr != '0);
        md_go     = !rst && (force_wr || (!wb_go && head_live));
        // An MDU result arriving alongside a newer WB write to the same register is stale.
        push_dead = wb_go && (md_waddr == wb_waddr);
        stall     = !rst && force_wr;
        rf_we     = wb_go || md_go;
        rf_waddr  = md_go ? head_addr : wb_waddr;
        rf_wdata  = md_go ? head_data : wb_wdata;
        hit_a     = !rst && fifo_hit_a;
        hit_b     = !rst && fifo_hit_b;
        if (!head_live || md_go) begin
            wait_d = '0;
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Head age counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        md_valid;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        md_ready;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  qry_a;
    logic [4:0]  qry_b;
    logic        hit_a;
    logic        hit_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit        live;
        bit [4:0]  addr;
        bit [31:0] data;
    } ent_t;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata),
        .md_valid (md_valid),
        .md_waddr (md_waddr),
        .md_wdata (md_wdata),
        .md_ready (md_ready),
        .stall    (stall),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .qry_a    (qry_a),
        .qry_b    (qry_b),
        .hit_a    (hit_a),
        .hit_b    (hit_b)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we    = 1'b0;
        wb_waddr = 5'd0;
        wb_wdata = 32'd0;
        md_valid = 1'b0;
        md_waddr = 5'd0;
        md_wdata = 32'd0;
        qry_a    = 5'd0;
        qry_b    = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rst_md_ready got %0b exp 0", md_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got %0b exp 0", rf_we); end
        checks++; if ({hit_a, hit_b} !== 2'b00) begin errors++; $display("FAIL rst_hits got %b exp 00", {hit_a, hit_b}); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL post_rst_md_ready got %0b exp 1", md_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_rf_we got %0b exp 0", rf_we); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall got %0b exp 0", stall); end
        step();
    endtask

    task automatic test_idle_write();
        do_reset();
        md_valid = 1'b1; md_waddr = 5'd5; md_wdata = 32'h0000_1234;
        @(negedge clk);
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %0b exp 1", md_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_no_early_we got %0b exp 0", rf_we); end
        step();
        md_valid = 1'b0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL idle_we got %0b exp 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL idle_waddr got %0d exp 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL idle_wdata got %h exp 00001234", rf_wdata); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL idle_ready2 got %0b exp 1", md_ready); end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_drained got %0b exp 0", rf_we); end
        step();
    endtask

    task automatic test_forced_write();
        do_reset();
        wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
        qry_a = 5'd8;
        for (int r = 0; r < 2; r++) begin
            md_valid = 1'b1; md_waddr = 5'd8; md_wdata = 32'h88 + r;
            @(negedge clk);
            checks++; if (stall !== 1'b0 || rf_waddr !== 5'd3) begin errors++; $display("FAIL force_enq_cycle stall=%0b waddr=%0d exp stall=0 waddr=3", stall, rf_waddr); end
            step();
            md_valid = 1'b0;
            for (int i = 0; i < MAX_WAIT; i++) begin
                @(negedge clk);
                checks++; if (stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd3) begin errors++; $display("FAIL force_defer%0d stall=%0b we=%0b waddr=%0d exp 0/1/3", i, stall, rf_we, rf_waddr); end
                checks++; if (hit_a !== 1'b1) begin errors++; $display("FAIL force_hit%0d got %0b exp 1", i, hit_a); end
                step();
            end
            @(negedge clk);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL force_stall got %0b exp 1", stall); end
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88 + r) begin errors++; $display("FAIL force_write we=%0b waddr=%0d data=%h exp 1/8/%h", rf_we, rf_waddr, rf_wdata, 32'h88 + r); end
            step();
        end
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rf_waddr !== 5'd3 || hit_a !== 1'b0) begin errors++; $display("FAIL force_after stall=%0b waddr=%0d hit=%0b exp 0/3/0", stall, rf_waddr, hit_a); end
        step();
    endtask

    task automatic test_kill();
        do_reset();
        wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
        md_valid = 1'b1; md_waddr = 5'd9; md_wdata = 32'hAAAA;
        qry_a = 5'd9;
        step();
        md_valid = 1'b0;
        wb_waddr = 5'd9; wb_wdata = 32'hBBBB;
        @(negedge clk);
        checks++; if (hit_a !== 1'b1) begin errors++; $display("FAIL kill_hit_before got %0b exp 1", hit_a); end
        checks++; if (rf_waddr !== 5'd9 || rf_wdata !== 32'hBBBB) begin errors++; $display("FAIL kill_wb_write waddr=%0d data=%h exp 9/0000bbbb", rf_waddr, rf_wdata); end
        step();
        wb_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL kill_hit_after%0d got %0b exp 0", i, hit_a); end
            checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL kill_stale_write%0d we=%0b data=%h exp we=0", i, rf_we, rf_wdata); end
            step();
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
        md_valid = 1'b1; md_waddr = 5'd10; md_wdata = 32'd1;
        @(negedge clk);
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_ready0 got %0b exp 1", md_ready); end
        step();
        md_waddr = 5'd11; md_wdata = 32'd2;
        @(negedge clk);
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %0b exp 1", md_ready); end
        step();
        md_waddr = 5'd12; md_wdata = 32'd3;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_ready_c%0d got %0b exp 0", k, md_ready); end
            checks++; if (stall !== (k == 5)) begin errors++; $display("FAIL full_stall_c%0d got %0b exp %0b", k, stall, (k == 5)); end
            step();
        end
        @(negedge clk);
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0b exp 1", md_ready); end
        step();
        md_valid = 1'b0;
        wb_we = 1'b0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'd2) begin errors++; $display("FAIL full_drain1 we=%0b waddr=%0d data=%h exp 1/11/2", rf_we, rf_waddr, rf_wdata); end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'd3) begin errors++; $display("FAIL full_drain2 we=%0b waddr=%0d data=%h exp 1/12/3", rf_we, rf_waddr, rf_wdata); end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_empty got %0b exp 0", rf_we); end
        step();
    endtask

    task automatic test_reg_zero();
        do_reset();
        md_valid = 1'b1; md_waddr = 5'd0; md_wdata = 32'h5555;
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h6666;
        @(negedge clk);
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", md_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %0b exp 0", rf_we); end
        step();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (rf_we !== 1'b0 || md_ready !== 1'b1) begin errors++; $display("FAIL r0_after%0d we=%0b ready=%0b exp 0/1", i, rf_we, md_ready); end
            step();
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
        qry_a = 5'd20; qry_b = 5'd21;
        md_valid = 1'b1; md_waddr = 5'd20; md_wdata = 32'h20;
        step();
        md_waddr = 5'd21; md_wdata = 32'h21;
        step();
        md_valid = 1'b0;
        step();
        @(negedge clk);
        checks++; if ({hit_a, hit_b} !== 2'b11) begin errors++; $display("FAIL midrst_hits_before got %b exp 11", {hit_a, hit_b}); end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rf_we !== 1'b0 || md_ready !== 1'b0) begin errors++; $display("FAIL midrst_during stall=%0b we=%0b ready=%0b exp 0/0/0", stall, rf_we, md_ready); end
        step();
        rst = 1'b0;
        wb_we = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL midrst_after stall=%0b we=%0b exp 0/0", stall, rf_we); end
        checks++; if ({hit_a, hit_b} !== 2'b00) begin errors++; $display("FAIL midrst_hits got %b exp 00", {hit_a, hit_b}); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %0b exp 1", md_ready); end
        step();
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL midrst_no_write got %0b exp 0", rf_we); end
        step();
    endtask

    task automatic test_random();
        ent_t      mq[$];
        int        mw;
        bit        hl, frc, wbg, mdg, acc, pop;
        bit        e_ready, e_stall, e_we, e_ha, e_hb;
        bit [4:0]  e_addr;
        bit [31:0] e_data;
        ent_t      ne;
        do_reset();
        mq.delete();
        mw = 0;
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            wb_we    = ($urandom_range(0, 2) != 0);
            wb_waddr = 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            md_valid = ($urandom_range(0, 1) != 0);
            md_waddr = 5'($urandom_range(0, 7));
            md_wdata = $urandom;
            qry_a    = 5'($urandom_range(0, 7));
            qry_b    = 5'($urandom_range(0, 7));
            hl = 0; frc = 0; wbg = 0; mdg = 0;
            e_ready = 0; e_stall = 0; e_we = 0; e_ha = 0; e_hb = 0;
            e_addr = 0; e_data = 0;
            if (!rst) begin
                hl      = (mq.size() > 0) && mq[0].live;
                frc     = hl && (mw == MAX_WAIT);
                wbg     = !frc && wb_we && (wb_waddr != 0);
                mdg     = frc || (!wbg && hl);
                e_ready = (mq.size() < DEPTH);
                e_stall = frc;
                e_we    = wbg || mdg;
                e_addr  = mdg ? mq[0].addr : wb_waddr;
                e_data  = mdg ? mq[0].data : wb_wdata;
                foreach (mq[i]) begin
                    if (mq[i].live && mq[i].addr == qry_a && qry_a != 0) e_ha = 1;
                    if (mq[i].live && mq[i].addr == qry_b && qry_b != 0) e_hb = 1;
                end
            end
            @(negedge clk);
            checks++; if (md_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %0b exp %0b", c, md_ready, e_ready); end
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall c%0d got %0b exp %0b", c, stall, e_stall); end
            checks++; if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we c%0d got %0b exp %0b", c, rf_we, e_we); end
            if (e_we) begin
                checks++; if (rf_waddr !== e_addr || rf_wdata !== e_data) begin errors++; $display("FAIL rnd_write c%0d got %0d/%h exp %0d/%h", c, rf_waddr, rf_wdata, e_addr, e_data); end
            end
            checks++; if ({hit_a, hit_b} !== {e_ha, e_hb}) begin errors++; $display("FAIL rnd_hits c%0d got %b exp %b", c, {hit_a, hit_b}, {e_ha, e_hb}); end
            if (rst) begin
                mq.delete();
                mw = 0;
            end else begin
                acc = md_valid && e_ready;
                pop = (mq.size() > 0) && (mdg || !mq[0].live);
                if (!hl || mdg) mw = 0;
                else if (mw < MAX_WAIT) mw = mw + 1;
                if (wbg) begin
                    foreach (mq[i]) if (mq[i].addr == wb_waddr) mq[i].live = 0;
                end
                if (pop) void'(mq.pop_front());
                if (acc && md_waddr != 0) begin
                    ne.live = !(wbg && md_waddr == wb_waddr);
                    ne.addr = md_waddr;
                    ne.data = md_wdata;
                    mq.push_back(ne);
                end
            end
            step();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_idle_write();
        test_forced_write();
        test_kill();
        test_full_backpressure();
        test_reg_zero();
        test_reset_midway();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
